// File: rtl/layer_mac_sched.sv
// Fully connected layer sequencer: drives one shared Q8.8 multiplier through
// N_OUT neurons of N_IN terms, saturating-accumulates products, writes act(acc).
module layer_mac_sched #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int RELU  = 1,
  parameter int AW    = 4,
  parameter int WAW   = 4,
  parameter int YW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           START,
  output logic [AW-1:0]  A_ADDR,
  output logic [WAW-1:0] W_ADDR,
  input  logic [15:0]    MUL_P,
  output logic [YW-1:0]  Y_ADDR,
  output logic [15:0]    Y_DATA,
  output logic           Y_WE,
  output logic           BUSY,
  output logic           DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } state_t;

  state_t      state, state_nxt;
  logic [YW-1:0] j;
  logic        dcnt;
  logic        v1, v2;
  logic [15:0] acc, acc_sat, acc_nxt, y_act;
  logic [16:0] sum;
  logic        last_i, last_j;

  // A_ADDR doubles as the input index i; W_ADDR runs linearly across neurons.
  assign last_i = (A_ADDR == AW'(N_IN - 1));
  assign last_j = (j == YW'(N_OUT - 1));

  always_comb begin
    sum = {acc[15], acc} + {MUL_P[15], MUL_P};
    if (sum[16] != sum[15])
      acc_sat = sum[16] ? 16'h8000 : 16'h7FFF;
    else
      acc_sat = sum[15:0];
    acc_nxt = v2 ? acc_sat : acc;
    y_act   = ((RELU != 0) && acc_nxt[15]) ? '0 : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    Y_WE      = 1'b0;
    case (state)
      S_IDLE:  if (START) state_nxt = S_ISSUE;
      S_ISSUE: begin
        BUSY = 1'b1;
        if (last_i) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        BUSY = 1'b1;
        if (dcnt) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        BUSY      = 1'b1;
        Y_WE      = 1'b1;
        state_nxt = last_j ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A_ADDR <= '0;
      W_ADDR <= '0;
      Y_ADDR <= '0;
      Y_DATA <= '0;
      j      <= '0;
      dcnt   <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      acc    <= '0;
    end else begin
      v1  <= (state == S_ISSUE);
      v2  <= v1;
      acc <= acc_nxt;
      case (state)
        S_IDLE: if (START) begin
          A_ADDR <= '0;
          W_ADDR <= '0;
          j      <= '0;
          dcnt   <= 1'b0;
          acc    <= '0;
        end
        S_ISSUE: begin
          dcnt <= 1'b0;
          if (!last_i) begin
            A_ADDR <= A_ADDR + 1'b1;
            W_ADDR <= W_ADDR + 1'b1;
          end
        end
        S_DRAIN: begin
          dcnt <= ~dcnt;
          // Last product lands this cycle, so the result is taken from acc_nxt.
          if (dcnt) begin
            Y_DATA <= y_act;
            Y_ADDR <= j;
          end
        end
        S_WRITE: if (!last_j) begin
          j      <= j + 1'b1;
          A_ADDR <= '0;
          W_ADDR <= W_ADDR + 1'b1;
          acc    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_sched.sv
// Directed bench for layer_mac_sched: RELU=1 and RELU=0 instances share stimulus
// and a product model emulating 1-cycle memory plus a registered multiplier.
module tb_layer_mac_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mul_p = '0;
  logic [15:0] p1 = '0;

  logic [3:0]  a0, a1;
  logic [3:0]  w0, w1;
  logic [1:0]  ya0, ya1;
  logic [15:0] yd0, yd1;
  logic        we0, we1, busy0, busy1, done0, done1;

  int mode = 0;
  int n_chk = 0;
  int n_pass = 0;

  layer_mac_sched #(.N_IN(4), .N_OUT(3), .RELU(1), .AW(4), .WAW(4), .YW(2)) dut_relu (
    .clk(clk), .rst(rst), .START(start), .A_ADDR(a0), .W_ADDR(w0), .MUL_P(mul_p),
    .Y_ADDR(ya0), .Y_DATA(yd0), .Y_WE(we0), .BUSY(busy0), .DONE(done0));

  layer_mac_sched #(.N_IN(4), .N_OUT(3), .RELU(0), .AW(4), .WAW(4), .YW(2)) dut_lin (
    .clk(clk), .rst(rst), .START(start), .A_ADDR(a1), .W_ADDR(w1), .MUL_P(mul_p),
    .Y_ADDR(ya1), .Y_DATA(yd1), .Y_WE(we1), .BUSY(busy1), .DONE(done1));

  always #5 clk = ~clk;

  function automatic logic [15:0] prod(input int m, input logic [3:0] w);
    case (m)
      0: prod = 16'h0080;
      1: prod = 16'h4000;
      2: prod = 16'hC000;
      default: prod = (w >= 4 && w < 8) ? 16'hFFC0 : 16'h0100;
    endcase
  endfunction

  function automatic logic [15:0] exp_y(input int m, input bit relu, input int n);
    case (m)
      0: exp_y = 16'h0200;
      1: exp_y = 16'h7FFF;
      2: exp_y = relu ? 16'h0000 : 16'h8000;
      default: exp_y = (n == 1) ? (relu ? 16'h0000 : 16'hFF00) : 16'h0400;
    endcase
  endfunction

  // Memory read + registered multiplier: address in cycle c -> MUL_P in c+2.
  always @(posedge clk) begin
    p1    <= prod(mode, w0);
    mul_p <= p1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic go(input int m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
  endtask

  // Checks cycles 1..22 after the START-sampling edge.
  task automatic run_cycles(input bit drop_start, input bit repulse);
    for (int k = 1; k <= 22; k++) begin
      int n, pos, ea;
      @(negedge clk);
      if (k == 1 && drop_start) start = 1'b0;
      if (repulse && k == 5) start = 1'b1;
      if (repulse && k == 6) start = 1'b0;
      n   = (k - 1) / 7;
      pos = (k - 1) % 7;
      chk($sformatf("busy c%0d", k), {15'b0, busy0}, 16'(k <= 21));
      chk($sformatf("busy_lin c%0d", k), {15'b0, busy1}, 16'(k <= 21));
      chk($sformatf("done c%0d", k), {15'b0, done0}, 16'(k == 22));
      chk($sformatf("done_lin c%0d", k), {15'b0, done1}, 16'(k == 22));
      chk($sformatf("y_we c%0d", k), {15'b0, we0}, 16'(k <= 21 && pos == 6));
      if (k <= 21) begin
        ea = (pos < 4) ? pos : 3;
        chk($sformatf("a_addr c%0d", k), {12'b0, a0}, 16'(ea));
        chk($sformatf("w_addr c%0d", k), {12'b0, w0}, 16'(n * 4 + ea));
      end
      if (k <= 21 && pos == 6) begin
        chk($sformatf("y_addr n%0d", n), {14'b0, ya0}, 16'(n));
        chk($sformatf("y_relu m%0d n%0d", mode, n), yd0, exp_y(mode, 1'b1, n));
        chk($sformatf("y_lin m%0d n%0d", mode, n), yd1, exp_y(mode, 1'b0, n));
      end
    end
  endtask

  initial begin
    int dcount;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst a_addr", {12'b0, a0}, 16'h0);
    chk("rst w_addr", {12'b0, w0}, 16'h0);
    chk("rst y_data", yd0, 16'h0);
    chk("rst y_we", {15'b0, we0}, 16'h0);
    chk("rst busy", {15'b0, busy0}, 16'h0);
    chk("rst done", {15'b0, done0}, 16'h0);
    rst = 1'b0;

    go(0); run_cycles(1'b1, 1'b0);   // basic pass
    go(0); run_cycles(1'b1, 1'b1);   // START re-pulse while busy is ignored
    go(1); run_cycles(1'b1, 1'b0);   // positive saturation
    go(2); run_cycles(1'b1, 1'b0);   // negative saturation
    go(3); run_cycles(1'b1, 1'b0);   // relu

    // START held: second pass starts after one IDLE cycle
    go(0); run_cycles(1'b0, 1'b0);
    @(negedge clk);
    chk("held idle busy", {15'b0, busy0}, 16'h0);
    chk("held idle done", {15'b0, done0}, 16'h0);
    @(posedge clk);
    run_cycles(1'b1, 1'b0);

    // reset during neuron 1 WRITE
    go(3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", {15'b0, busy0}, 16'h0);
    chk("mid rst y_we", {15'b0, we0}, 16'h0);
    chk("mid rst done", {15'b0, done0}, 16'h0);
    chk("mid rst a_addr", {12'b0, a0}, 16'h0);
    chk("mid rst w_addr", {12'b0, w0}, 16'h0);
    chk("mid rst y_addr", {14'b0, ya0}, 16'h0);
    chk("mid rst y_data", yd0, 16'h0);
    chk("mid rst y_data_lin", yd1, 16'h0);
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done0 || done1 || we0) dcount++;
    end
    chk("no done/we after abort", 16'(dcount), 16'h0);

    go(3); run_cycles(1'b1, 1'b0);   // normal pass after abort

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
